// File: rtl/mips_inst_loader.sv
// Boot loader that turns a length-prefixed byte stream into big-endian instruction-memory word writes.
// Optional trailing XOR checksum byte is enabled by defining INST_LOADER_CHECKSUM_EN.
module mips_inst_loader #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_run
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef INST_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] len_q, len_d;
  logic [15:0] widx_q, widx_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        xfer;
  logic [15:0] length;

  assign xfer   = in_valid && in_ready_q;
  assign length = {len_hi_q, in_data};

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    widx_d      = widx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    err_d       = err_q;
`ifdef INST_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    // After the final data word, DONE is entered during the write cycle; done rises one cycle later.
    if (state_q == S_DONE && !done_q) begin
      done_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          done_d     = 1'b0;
          err_d      = 1'b0;
          widx_d     = '0;
          byte_cnt_d = '0;
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = in_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = length;
          if (length == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if ({16'd0, length} > DEPTH_U) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], in_data};
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {14'd0, widx_q, 2'b00};
            mem_wdata_d = {shift_q, in_data};
            widx_d      = widx_q + 16'd1;
            if (widx_q == len_q - 16'd1) begin
`ifdef INST_LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          if (in_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    in_ready_d = state_d inside {S_LEN_HI, S_LEN_LO, S_DATA};
`ifdef INST_LOADER_CHECKSUM_EN
    if (state_d == S_CHK) in_ready_d = 1'b1;
`endif
    busy_d = in_ready_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      len_hi_q    <= '0;
      len_q       <= '0;
      widx_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      widx_q      <= widx_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_run   = done_q;

endmodule

// File: tb/tb_mips_inst_loader.sv
// Bench for mips_inst_loader: frame-level reference model checked every cycle plus literal spot checks.
// Define INST_LOADER_CHECKSUM_EN for both bench and RTL to exercise the checksum frames.
module tb_mips_inst_loader;
  localparam int DEPTH = 1024;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, busy, done, err, cpu_run;
  logic [31:0] mem_addr, mem_wdata;

  mips_inst_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .cpu_run(cpu_run)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t wlog[$];

  // Frame-level reference: position within the frame decides what each accepted byte means.
  bit          m_active = 0;
  bit          m_xfer = 0;
  bit          m_pending = 0;
  int          m_pos = 0, m_flen = 0, m_n = 0;
  logic [7:0]  m_hi = 8'h00, m_xsum = 8'h00;
  logic [7:0]  m_bytes[$];
  logic        m_ready = 0, m_we = 0, m_busy = 0, m_done = 0, m_err = 0;
  logic [31:0] m_addr = 0, m_data = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit         n_we, n_done, n_err;
    logic [7:0] b;
    int         d;
    cyc++;
    chk32("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    chk32("mem_we", {31'd0, mem_we}, {31'd0, m_we});
    chk32("mem_addr", mem_addr, m_addr);
    chk32("mem_wdata", mem_wdata, m_data);
    chk32("busy", {31'd0, busy}, {31'd0, m_busy});
    chk32("done", {31'd0, done}, {31'd0, m_done});
    chk32("err", {31'd0, err}, {31'd0, m_err});
    chk32("cpu_run", {31'd0, cpu_run}, {31'd0, m_done});
    if (mem_we === 1'b1) wlog.push_back('{cyc, mem_addr, mem_wdata});

    m_xfer = 0;
    if (!rst) begin
      m_active = 0; m_pending = 0;
      m_ready = 0; m_we = 0; m_busy = 0; m_done = 0; m_err = 0;
      m_addr = 0; m_data = 0;
    end else begin
      n_we = 0;
      n_done = m_done | m_pending;
      n_err = m_err;
      m_pending = 0;
      if (m_active && in_valid && m_pos < m_flen) begin
        m_xfer = 1;
        b = in_data;
        if (m_pos == 0) begin
          m_hi = b;
        end else if (m_pos == 1) begin
          m_n = int'({m_hi, b});
          if (m_n == 0) begin
            m_active = 0; n_done = 1;
          end else if (m_n > DEPTH) begin
            m_active = 0; n_err = 1;
          end else begin
            m_flen = 2 + 4 * m_n + CHK_BYTES;
          end
        end else if (m_pos < 2 + 4 * m_n) begin
          d = m_pos - 2;
          m_bytes.push_back(b);
          m_xsum = m_xsum ^ b;
          if (d % 4 == 3) begin
            n_we = 1;
            m_addr = 32'((d / 4) * 4);
            m_data = {m_bytes[d-3], m_bytes[d-2], m_bytes[d-1], m_bytes[d]};
            if (d == 4 * m_n - 1 && CHK_BYTES == 0) begin
              m_active = 0; m_pending = 1;
            end
          end
        end else begin
          m_active = 0;
          if (b == m_xsum) n_done = 1;
          else n_err = 1;
        end
        m_pos++;
      end else if (start && !m_active) begin
        m_active = 1; m_pos = 0; m_flen = 2; m_n = 0;
        n_done = 0; n_err = 0; m_pending = 0;
        m_bytes.delete(); m_xsum = 8'h00;
      end
      m_we = n_we;
      m_done = n_done;
      m_err = n_err;
      m_ready = m_active && (m_pos < m_flen);
      m_busy = m_active;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data = b;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk);
      got = m_xfer;
    end
    #1;
    in_valid = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL handshake_timeout byte=%h actual=no_transfer required=transfer", b);
    end
  endtask

  task automatic send_frame(input logic [127:0] fb, input int nbytes, input int gap);
    for (int i = 0; i < nbytes; i++) send_byte(fb[8*(nbytes-1-i) +: 8], gap);
  endtask

  task automatic chk_one_write(input string name, input logic [31:0] addr, input logic [31:0] data);
    chk32({name, "_nwr"}, 32'(wlog.size()), 32'd1);
    if (wlog.size() >= 1) begin
      chk32({name, "_addr"}, wlog[0].addr, addr);
      chk32({name, "_data"}, wlog[0].data, data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);
    chk32("reset_done", {31'd0, done}, 32'd0);
    chk32("reset_ready", {31'd0, in_ready}, 32'd0);

    // N=2 back-to-back words
    wlog.delete();
    pulse_start();
    send_frame({8'h00, 8'h02, 8'h20, 8'h11, 8'h00, 8'h0a, 8'h20, 8'h12, 8'h00, 8'h14}, 10, 0);
    idle(4);
    chk32("t1_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() >= 2) begin
      chk32("t1_addr0", wlog[0].addr, 32'h0);
      chk32("t1_data0", wlog[0].data, 32'h2011000a);
      chk32("t1_addr1", wlog[1].addr, 32'h4);
      chk32("t1_data1", wlog[1].data, 32'h20120014);
      chk32("t1_spacing", 32'(wlog[1].cyc - wlog[0].cyc), 32'd4);
    end
    chk32("t1_cpu_run", {31'd0, cpu_run}, 32'd1);

    // N=1 with in_valid toggling
    wlog.delete();
    pulse_start();
    send_frame({8'h00, 8'h01, 8'h00, 8'h00, 8'h80, 8'h20}, 6, 1);
    idle(4);
    chk_one_write("t2", 32'h0, 32'h00008020);
    chk32("t2_done", {31'd0, done}, 32'd1);

    // N=0
    wlog.delete();
    pulse_start();
    send_frame({8'h00, 8'h00}, 2, 0);
    idle(3);
    chk32("t3_nwr", 32'(wlog.size()), 32'd0);
    chk32("t3_done", {31'd0, done}, 32'd1);

    // N=1025 > DEPTH, then recover with a valid frame
    wlog.delete();
    pulse_start();
    send_frame({8'h04, 8'h01}, 2, 0);
    idle(3);
    chk32("t4_nwr", 32'(wlog.size()), 32'd0);
    chk32("t4_err", {31'd0, err}, 32'd1);
    chk32("t4_ready", {31'd0, in_ready}, 32'd0);
    pulse_start();
    send_frame({8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04}, 6, 0);
    idle(4);
    chk_one_write("t4b", 32'h0, 32'h01020304);
    chk32("t4b_err", {31'd0, err}, 32'd0);
    chk32("t4b_done", {31'd0, done}, 32'd1);

    // reset after two data bytes of an N=3 load
    pulse_start();
    send_frame({8'h00, 8'h03, 8'haa, 8'hbb}, 4, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
    chk32("t5_wdata_rst", mem_wdata, 32'h0);
    wlog.delete();
    pulse_start();
    send_frame({8'h00, 8'h01, 8'hde, 8'had, 8'hbe, 8'hef}, 6, 0);
    idle(4);
    chk_one_write("t5", 32'h0, 32'hdeadbeef);

`ifdef INST_LOADER_CHECKSUM_EN
    wlog.delete();
    pulse_start();
    send_frame({8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08}, 7, 0);
    idle(3);
    chk_one_write("t6", 32'h0, 32'h12345678);
    chk32("t6_done", {31'd0, done}, 32'd1);
    wlog.delete();
    pulse_start();
    send_frame({8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09}, 7, 0);
    idle(3);
    chk_one_write("t7", 32'h0, 32'h12345678);
    chk32("t7_err", {31'd0, err}, 32'd1);
    chk32("t7_cpu_run", {31'd0, cpu_run}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_inst_loader.md
# mips_inst_loader

Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and drives a word-write port into instruction memory at byte addresses 0, 4, 8, … (memory index = addr>>2). It holds the CPU out of run until the whole program is written. It sits between the host/UART byte source and the instruction memory's write side.

## Interface
Parameters:
- DEPTH, 1024, instruction memory size in words; upper limit on the word count.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-low reset
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- in_data  input  8  stream byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction memory write strobe, one cycle per word
- mem_addr  output  32  byte address of the word being written (word_index<<2)
- mem_wdata  output  32  instruction word
- busy  output  1  load in progress
- done  output  1  load completed successfully; sticky until the next start or reset
- err  output  1  load aborted; sticky until the next start or reset
- cpu_run  output  1  CPU release; equals done

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N×4 data bytes, MSB first within each word.
- A byte transfers on a cycle where in_valid && in_ready.
- FSM states and transitions:
  - IDLE → LEN_HI on start.
  - LEN_HI → LEN_LO on transfer.
  - LEN_LO → DATA on transfer when 0 < N ≤ DEPTH.
  - LEN_LO → DONE on transfer when N = 0.
  - LEN_LO → ERR on transfer when N > DEPTH.
  - DATA → DONE after the 4th byte of word N-1 (CHK first when configured).
  - DONE/ERR → LEN_HI on start.
- in_ready is 1 only in LEN_HI, LEN_LO, DATA (and CHK); in all other states it is 0.
- A 2-bit byte counter and a shift register assemble each word. The word index counter is 10+ bits wide, clears on start, and increments after each write.
- start is ignored in LEN_HI/LEN_LO/DATA/CHK.
- A start pulse clears done, err and the word index.
- busy = 1 in LEN_HI, LEN_LO, DATA, CHK.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_run=0. State is IDLE.
- Write latency: mem_we pulses for exactly one cycle, in the cycle after the 4th byte of a word transfers. mem_addr and mem_wdata are registered and valid in that same cycle, and hold until the next write.
- Throughput: one byte per cycle. in_ready stays high across a write cycle, so back-to-back words need no stall.
- done/cpu_run rise the cycle after the final byte's write strobe. For N=0 they rise the cycle after the LEN_LO transfer.
- err rises the cycle after the offending LEN_LO transfer. No mem_we is issued in that case.
- Reset mid-load: every output returns to its reset value on the next edge. Words already written are left in memory. A partial word is discarded.
- start in the same cycle as a transfer while busy: start is ignored and the transfer proceeds.

## Configuration
- INST_LOADER_CHECKSUM_EN defined: a CHK state follows the last data byte and accepts one checksum byte.
  - The checksum is the XOR of all data bytes; the length bytes are excluded.
  - Match → DONE, one cycle after the checksum transfer.
  - Mismatch → ERR: err=1, cpu_run stays 0. Memory contents stay as written.
- INST_LOADER_CHECKSUM_EN undefined: no CHK state, no checksum logic. DATA goes directly to DONE.

## Test plan
- Load N=2, bytes 20 11 00 0a 20 12 00 14 with in_valid continuously high:
  - mem_we at addr 0x0 with 0x2011000a, then at 0x4 with 0x20120014, on consecutive-word timing.
  - done=cpu_run=1 one cycle after the last write.
- Load N=1, bytes 00 00 80 20, with in_valid toggling every other cycle → a single write of 0x00008020 at addr 0. There are no extra strobes.
- Load N=0 → no mem_we; done=1 the cycle after LEN_LO.
- Load N=1025 with DEPTH=1024 → err=1, in_ready=0, no mem_we. Then start with a valid N=1 frame → err clears and the load completes.
- Apply rst=0 after 2 data bytes of an N=3 load → all outputs reset. A fresh N=1 load then writes at addr 0.
- With INST_LOADER_CHECKSUM_EN, load N=1, bytes 12 34 56 78:
  - Checksum 0x08 → done=1.
  - Checksum 0x09 → err=1, cpu_run=0, and the single write of 0x12345678 at addr 0 still occurs.
